// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//  Walks the program counter through a multi-cycle fetch/execute loop:
//  IDLE -> FETCH (imem request at pc) -> EXEC (instruction held for the core)
//  -> FETCH ... with terminal HALT and ERR states that only reset leaves.
//  Retire = exec_done & ~stall; on retire the pc moves to pc+4 or to the
//  branch target and the 32-bit retired-instruction counter increments.
//  Optional feature macro: PC_SEQ_ALIGN_CHK_EN
//    defined   -> a retire whose next pc is not 4-byte aligned goes to ERR
//                 with misalign_err set, and pc/instret are left untouched.
//    undefined -> no alignment check, misalign_err is constant 0.
//  Reset is synchronous and active-low (reset = 0 at a posedge).
module pc_fetch_sequencer #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            exec_done,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            halt,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instret,
    output logic            halted,
    output logic            fetch_err,
    output logic            misalign_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [31:0]       instret_reg;
    logic [31:0]       instr_reg;
    logic [XLEN-1:0]   instr_pc_reg;
    logic              imem_req_reg;
    logic              instr_valid_reg;
    logic              halted_reg;
    logic              fetch_err_reg;
    logic              retire;
    logic [XLEN-1:0]   pc_next;
`ifdef PC_SEQ_ALIGN_CHK_EN
    logic              misalign_err_reg;
`endif

    // Retire qualification and candidate next pc (wraps naturally at 2^XLEN)
    always_comb begin
        retire  = (state_reg == ST_EXEC) && exec_done && !stall;
        pc_next = branch_taken ? branch_target : (pc_reg + XLEN'(4));
    end

    // Sequencer FSM with registered Moore outputs, datapath registers alongside
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            pc_reg           <= RESET_VEC;
            instret_reg      <= '0;
            instr_reg        <= '0;
            instr_pc_reg     <= '0;
            imem_req_reg     <= 1'b0;
            instr_valid_reg  <= 1'b0;
            halted_reg       <= 1'b0;
            fetch_err_reg    <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHK_EN
            misalign_err_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (halt) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg    <= ST_FETCH;
                        imem_req_reg <= 1'b1;
                        cnt_reg      <= '0;
                    end
                end

                ST_FETCH: begin
                    // An ack in the final timeout cycle still counts as a fetch
                    if (imem_ack) begin
                        instr_reg       <= imem_rdata;
                        instr_pc_reg    <= pc_reg;
                        state_reg       <= ST_EXEC;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                        cnt_reg         <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg     <= ST_ERR;
                        imem_req_reg  <= 1'b0;
                        fetch_err_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                ST_EXEC: begin
                    if (retire) begin
                        instr_valid_reg <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHK_EN
                        // Faulting retire: pc stays on the offending instruction
                        if (pc_next[1:0] != 2'b00) begin
                            state_reg        <= ST_ERR;
                            misalign_err_reg <= 1'b1;
                        end else
`endif
                        begin
                            pc_reg      <= pc_next;
                            instret_reg <= instret_reg + 32'd1;
                            if (halt) begin
                                state_reg  <= ST_HALT;
                                halted_reg <= 1'b1;
                            end else begin
                                state_reg    <= ST_FETCH;
                                imem_req_reg <= 1'b1;
                                cnt_reg      <= '0;
                            end
                        end
                    end
                end

                ST_HALT: begin
                    state_reg <= ST_HALT;
                end

                ST_ERR: begin
                    state_reg <= ST_ERR;
                end

                default: begin
                    state_reg       <= ST_ERR;
                    imem_req_reg    <= 1'b0;
                    instr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_reg;
    assign imem_addr   = pc_reg;
    assign instr_valid = instr_valid_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign pc          = pc_reg;
    assign instret     = instret_reg;
    assign halted      = halted_reg;
    assign fetch_err   = fetch_err_reg;
`ifdef PC_SEQ_ALIGN_CHK_EN
    assign misalign_err = misalign_err_reg;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer
//  Randomized self-checking bench. A transaction-level model keeps the
//  architectural pc, retired count and current instruction; every fetch and
//  retire is compared against it. Inputs are driven and outputs sampled on
//  the falling clock edge.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        exec_done;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        halt;
    logic [63:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic        fetch_err;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [63:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .exec_done     (exec_done),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .pc            (pc),
        .instret       (instret),
        .halted        (halted),
        .fetch_err     (fetch_err),
        .misalign_err  (misalign_err)
    );

    task automatic clear_inputs();
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        exec_done     = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        halt          = 1'b0;
    endtask

    // reset for two cycles, release, and let one IDLE cycle pass
    task automatic do_reset(input bit hlt);
        reset = 1'b0;
        clear_inputs();
        halt = hlt;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        m_pc      = 64'h0;
        m_instret = 32'd0;
        m_instr   = 32'd0;
        @(negedge clk);
        halt = 1'b0;
    endtask

    // entry: DUT in FETCH. Waits 'waits' cycles (random noise on ignored inputs), then acks.
    task automatic do_fetch(input int waits, input logic [31:0] rdata);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            errors++;
            $display("FAIL fetch_entry: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, m_pc);
        end
        for (int i = 0; i < waits; i++) begin
            exec_done = 1'($urandom);
            stall     = 1'($urandom);
            halt      = 1'($urandom);
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || imem_addr !== m_pc) begin
                errors++;
                $display("FAIL fetch_wait%0d: req=%0b valid=%0b ferr=%0b addr=%h, required 1 0 0 %h",
                         i, imem_req, instr_valid, fetch_err, imem_addr, m_pc);
            end
        end
        clear_inputs();
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = rdata;
        checks++;
        if (instr_valid !== 1'b1 || instr !== m_instr || instr_pc !== m_pc || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_latch: valid=%0b instr=%h ipc=%h req=%0b, required 1 %h %h 0",
                     instr_valid, instr, instr_pc, imem_req, m_instr, m_pc);
        end
        $display("tb: fetch pc=%h waits=%0d instr=%h", m_pc, waits, rdata);
    endtask

    // entry: DUT in EXEC. Holds exec_done under stall, then retires.
    task automatic do_retire(input int stalls, input bit br, input logic [63:0] tgt, input bit hlt);
        logic [63:0] nxt;
        bit          bad;
        for (int i = 0; i < stalls; i++) begin
            exec_done     = 1'b1;
            stall         = 1'b1;
            branch_taken  = 1'($urandom);
            branch_target = {$urandom, $urandom};
            halt          = 1'($urandom);
            imem_ack      = 1'($urandom);
            imem_rdata    = $urandom;
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || pc !== m_pc || instret !== m_instret || instr !== m_instr || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: valid=%0b pc=%h instret=%0d instr=%h req=%0b, required 1 %h %0d %h 0",
                         i, instr_valid, pc, instret, instr, imem_req, m_pc, m_instret, m_instr);
            end
        end
        clear_inputs();
        exec_done     = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        halt          = hlt;
        @(negedge clk);
        clear_inputs();
        nxt = br ? tgt : m_pc + 64'd4;
`ifdef PC_SEQ_ALIGN_CHK_EN
        bad = (nxt[1:0] != 2'b00);
`else
        bad = 1'b0;
`endif
        if (bad) begin
            checks++;
            if (misalign_err !== 1'b1 || pc !== m_pc || instret !== m_instret || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_retire: merr=%0b pc=%h instret=%0d req=%0b valid=%0b, required 1 %h %0d 0 0",
                         misalign_err, pc, instret, imem_req, instr_valid, m_pc, m_instret);
            end
        end else begin
            m_pc      = nxt;
            m_instret = m_instret + 32'd1;
            checks++;
            if (pc !== m_pc || instret !== m_instret || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
                errors++;
                $display("FAIL retire: pc=%h instret=%0d valid=%0b merr=%0b, required %h %0d 0 0",
                         pc, instret, instr_valid, misalign_err, m_pc, m_instret);
            end
            checks++;
            if (hlt ? (halted !== 1'b1 || imem_req !== 1'b0)
                    : (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== m_pc)) begin
                errors++;
                $display("FAIL retire_next: halted=%0b req=%0b addr=%h, required halted=%0b req=%0b addr=%h",
                         halted, imem_req, imem_addr, hlt, !hlt, m_pc);
            end
        end
        $display("tb: retire stalls=%0d br=%0b halt=%0b pc=%h instret=%0d", stalls, br, hlt, m_pc, m_instret);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({imem_req, instr_valid, halted, fetch_err, misalign_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: req/valid/halted/ferr/merr=%b, required 00000",
                     {imem_req, instr_valid, halted, fetch_err, misalign_err});
        end
        checks++;
        if (pc !== 64'h0 || imem_addr !== 64'h0 || instret !== 32'd0 || instr !== 32'd0 || instr_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_values: pc=%h addr=%h instret=%0d instr=%h ipc=%h, required all 0",
                     pc, imem_addr, instret, instr, instr_pc);
        end
        reset     = 1'b1;
        m_pc      = 64'h0;
        m_instret = 32'd0;
        m_instr   = 32'd0;
        // still IDLE before the first active edge after release
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: req=%0b, required 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL first_fetch: req=%0b addr=%h, required 1 0", imem_req, imem_addr);
        end
        $display("tb: reset released, first fetch request");
    endtask

    task automatic test_basic_sequence();
        do_fetch(3, 32'h00500093);
        do_retire(0, 1'b0, 64'h0, 1'b0);
        do_fetch(1, 32'h00a00113);
        do_retire(2, 1'b1, 64'h100, 1'b0);
        checks++;
        if (imem_addr !== 64'h100 || instret !== 32'd2) begin
            errors++;
            $display("FAIL branch_redirect: addr=%h instret=%0d, required 100 2", imem_addr, instret);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_fetch(int'($urandom_range(0, 15)), $urandom);
            do_retire(int'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom} & ~64'h3, 1'b0);
        end
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: req=%0b ferr=%0b, required 1 0", i, imem_req, fetch_err);
            end
        end
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: ferr=%0b req=%0b valid=%0b, required 1 0 0", fetch_err, imem_req, instr_valid);
        end
        for (int i = 0; i < 4; i++) begin
            imem_ack  = 1'($urandom);
            exec_done = 1'($urandom);
            @(negedge clk);
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL err_sticky%0d: ferr=%0b req=%0b valid=%0b, required 1 0 0", i, fetch_err, imem_req, instr_valid);
            end
        end
        $display("tb: fetch timeout error raised");
        // ack exactly in the last allowed cycle
        do_reset(1'b0);
        do_fetch(15, 32'hdeadbeef);
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_timeout: ferr=%0b, required 0", fetch_err);
        end
        do_retire(0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic test_halt();
        do_reset(1'b0);
        do_fetch(0, $urandom);
        do_retire(1, 1'b1, 64'h200, 1'b1);
        for (int i = 0; i < 5; i++) begin
            imem_ack  = 1'($urandom);
            exec_done = 1'($urandom);
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 64'h200 || instret !== 32'd1) begin
                errors++;
                $display("FAIL halt_hold%0d: halted=%0b req=%0b valid=%0b pc=%h instret=%0d, required 1 0 0 200 1",
                         i, halted, imem_req, instr_valid, pc, instret);
            end
        end
        // halt seen in IDLE goes straight to HALT
        do_reset(1'b1);
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_idle: halted=%0b req=%0b, required 1 0", halted, imem_req);
        end
        $display("tb: halt scenarios done");
    endtask

    task automatic test_wrap_and_reset();
        do_reset(1'b0);
        do_fetch(0, $urandom);
        do_retire(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        do_fetch(2, $urandom);
        do_retire(0, 1'b0, 64'h0, 1'b0);
        checks++;
        if (pc !== 64'h0 || imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h addr=%h, required 0 0", pc, imem_addr);
        end
        do_fetch(1, $urandom);
        do_retire(0, 1'b0, 64'h0, 1'b0);
        // abort a fetch in progress with state far from reset values
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_req, instr_valid, halted, fetch_err, misalign_err} !== 5'b0 ||
            pc !== 64'h0 || instret !== 32'd0 || instr !== 32'd0 || instr_pc !== 64'h0) begin
            errors++;
            $display("FAIL midfetch_reset: flags=%b pc=%h instret=%0d instr=%h ipc=%h, required all 0",
                     {imem_req, instr_valid, halted, fetch_err, misalign_err}, pc, instret, instr, instr_pc);
        end
        $display("tb: wrap and mid-fetch reset done");
    endtask

    task automatic test_misalign();
        do_reset(1'b0);
        do_fetch(0, $urandom);
        do_retire(0, 1'b1, 64'h102, 1'b0);
`ifdef PC_SEQ_ALIGN_CHK_EN
        checks++;
        if (pc !== 64'h0 || misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_hold: pc=%h merr=%0b, required 0 1", pc, misalign_err);
        end
`else
        checks++;
        if (imem_addr !== 64'h102 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_free: addr=%h merr=%0b, required 102 0", imem_addr, misalign_err);
        end
        do_fetch(0, $urandom);
        do_retire(0, 1'b0, 64'h0, 1'b0);
`endif
        $display("tb: misaligned target handled");
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_basic_sequence();
        test_random();
        test_timeout();
        test_halt();
        test_wrap_and_reset();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
